// File: rtl/ulpi_tx_link_if.sv
// rtl/ulpi_tx_link_if.sv - ULPI bus bundle between link (master) and PHY (slave)
interface ulpi_tx_link_if;
   logic       ulpi_dir;
   logic       ulpi_nxt;
   logic [7:0] ulpi_data_in;
   logic [7:0] ulpi_data_out;
   logic       ulpi_data_oe;
   logic       ulpi_stp;

   modport master (
      input  ulpi_dir, ulpi_nxt, ulpi_data_in,
      output ulpi_data_out, ulpi_data_oe, ulpi_stp
   );

   modport slave (
      output ulpi_dir, ulpi_nxt, ulpi_data_in,
      input  ulpi_data_out, ulpi_data_oe, ulpi_stp
   );
endinterface

// File: rtl/ulpi_tx_link.sv
// rtl/ulpi_tx_link.sv - link-side ULPI transmit engine; optional ULPI_TX_REG_RETRY_EN
module ulpi_tx_link #(
   parameter int MAX_RETRY = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   ulpi_tx_link_if.master        ulpi,
   input  logic                  req_valid,
   input  logic [1:0]            req_type,
   input  logic [5:0]            req_addr,
   input  logic [7:0]            req_wdata,
   input  logic [3:0]            req_pid,
   output logic                  req_ready,
   input  logic [7:0]            tx_data,
   input  logic                  tx_valid,
   input  logic                  tx_last,
   output logic                  tx_ready,
   output logic [7:0]            rd_data,
   output logic                  rd_valid,
   output logic                  done,
   output logic                  aborted,
   output logic                  busy
);
   typedef enum logic [3:0] {
      IDLE, CMD, WDATA, TXDATA, STP, RD_TURN, RD_DATA, RD_END, ABORT
   } state_t;

   localparam logic [1:0] T_WR  = 2'd0;
   localparam logic [1:0] T_RD  = 2'd1;
   localparam logic [1:0] T_TX  = 2'd2;
   localparam logic [1:0] T_RSV = 2'd3;

   state_t     state, state_nxt;
   logic       dir_r, turnaround, oe, accept;
   logic [1:0] l_type;
   logic [5:0] l_addr;
   logic [7:0] l_wdata;
   logic [3:0] l_pid;
   logic       underrun, underrun_set;
   logic       done_nxt, aborted_nxt, rd_valid_nxt;
   logic       retry_left;
   logic [7:0] data_out;

   assign turnaround = ulpi.ulpi_dir != dir_r;
   assign oe         = !ulpi.ulpi_dir && !turnaround;
   assign accept     = (state == IDLE) && req_valid && (req_type != T_RSV) && oe;

   assign req_ready          = accept;
   assign tx_ready           = (state == TXDATA) && ulpi.ulpi_nxt && oe && tx_valid;
   assign busy               = state != IDLE;
   assign ulpi.ulpi_data_oe  = oe;
   assign ulpi.ulpi_stp      = state == STP;
   assign ulpi.ulpi_data_out = data_out;

`ifdef ULPI_TX_REG_RETRY_EN
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RW-1:0] retry_cnt;

   // Register ops interrupted by the PHY are silently replayed until the budget runs out.
   assign retry_left = (l_type != T_TX) && (retry_cnt != RW'(MAX_RETRY));

   always_ff @(posedge clk) begin
      if (reset)
         retry_cnt <= '0;
      else if (accept)
         retry_cnt <= '0;
      else if ((state == ABORT) && !ulpi.ulpi_dir && retry_left)
         retry_cnt <= retry_cnt + RW'(1);
   end
`else
   logic unused_retry;
   assign retry_left   = 1'b0;
   assign unused_retry = MAX_RETRY > 0;
`endif

   always_comb begin
      data_out = 8'h00;
      case (state)
         CMD: begin
            case (l_type)
               T_TX:    data_out = {4'h4, l_pid};
               T_RD:    data_out = {2'b11, l_addr};
               default: data_out = {2'b10, l_addr};
            endcase
         end
         WDATA:   data_out = l_wdata;
         TXDATA:  data_out = tx_data;
         STP:     data_out = underrun ? 8'hFF : 8'h00;
         default: data_out = 8'h00;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      done_nxt     = 1'b0;
      aborted_nxt  = 1'b0;
      rd_valid_nxt = 1'b0;
      underrun_set = 1'b0;
      case (state)
         IDLE: if (accept) state_nxt = CMD;
         CMD: begin
            if (ulpi.ulpi_dir)
               state_nxt = ABORT;
            else if (ulpi.ulpi_nxt && oe) begin
               case (l_type)
                  T_WR:    state_nxt = WDATA;
                  T_RD:    state_nxt = RD_TURN;
                  default: state_nxt = TXDATA;
               endcase
            end
         end
         WDATA: begin
            if (ulpi.ulpi_dir)
               state_nxt = ABORT;
            else if (ulpi.ulpi_nxt && oe) begin
               state_nxt = STP;
               done_nxt  = 1'b1;
            end
         end
         TXDATA: begin
            if (ulpi.ulpi_dir)
               state_nxt = ABORT;
            else if (ulpi.ulpi_nxt && oe) begin
               if (!tx_valid) begin
                  state_nxt    = STP;
                  underrun_set = 1'b1;
                  aborted_nxt  = 1'b1;
               end else if (tx_last) begin
                  state_nxt = STP;
                  done_nxt  = 1'b1;
               end
            end
         end
         STP: state_nxt = IDLE;
         RD_TURN: if (ulpi.ulpi_dir) state_nxt = ulpi.ulpi_nxt ? ABORT : RD_DATA;
         RD_DATA: begin
            if (ulpi.ulpi_dir) begin
               state_nxt    = RD_END;
               done_nxt     = 1'b1;
               rd_valid_nxt = 1'b1;
            end else
               state_nxt = ABORT;
         end
         RD_END: if (!ulpi.ulpi_dir) state_nxt = IDLE;
         ABORT: if (!ulpi.ulpi_dir) state_nxt = retry_left ? CMD : IDLE;
         default: state_nxt = IDLE;
      endcase
      // aborted is reported on entry to ABORT unless a replay will follow
      if ((state != ABORT) && (state_nxt == ABORT))
         aborted_nxt = !retry_left;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         dir_r    <= 1'b0;
         l_type   <= T_WR;
         l_addr   <= '0;
         l_wdata  <= '0;
         l_pid    <= '0;
         underrun <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         state    <= state_nxt;
         dir_r    <= ulpi.ulpi_dir;
         rd_valid <= rd_valid_nxt;
         done     <= done_nxt;
         aborted  <= aborted_nxt;
         if (accept) begin
            l_type   <= req_type;
            l_addr   <= req_addr;
            l_wdata  <= req_wdata;
            l_pid    <= req_pid;
            underrun <= 1'b0;
         end else if (underrun_set)
            underrun <= 1'b1;
         if ((state == RD_DATA) && ulpi.ulpi_dir)
            rd_data <= ulpi.ulpi_data_in;
      end
   end
endmodule

// File: doc/ulpi_tx_link.md
Name: ulpi_tx_link

Overview:
Link-side ULPI transmit engine, the outbound counterpart to the ULPI receive path that captures RX CMD and receive data. It accepts register-write, register-read and USB packet-transmit requests from the system side. It serialises each request as TX CMD, data and stp on the ULPI bus, honouring nxt/dir handshakes. Read data and completion/abort status are returned to the system side.

Parameters:
MAX_RETRY, 3, register-op retry limit; used only when ULPI_TX_REG_RETRY_EN is defined.

Ports:
clk  in  1  ULPI 60 MHz clock
reset  in  1  synchronous, active-high
ulpi_dir  in  1  PHY dir
ulpi_nxt  in  1  PHY nxt
ulpi_data_in  in  8  ULPI data sampled from the pad
ulpi_data_out  out  8  ULPI data driven by the link
ulpi_data_oe  out  1  pad output enable
ulpi_stp  out  1  ULPI stp
req_valid  in  1  request present
req_type  in  2  0 = reg write, 1 = reg read, 2 = transmit, 3 = reserved (ignored, never accepted)
req_addr  in  6  register address
req_wdata  in  8  register write data
req_pid  in  4  USB PID for transmit
req_ready  out  1  request accepted this cycle
tx_data  in  8  packet byte
tx_valid  in  1  packet byte present
tx_last  in  1  final packet byte
tx_ready  out  1  byte consumed this cycle
rd_data  out  8  register read result
rd_valid  out  1  one-cycle pulse, rd_data valid
done  out  1  one-cycle pulse, request completed
aborted  out  1  one-cycle pulse, request aborted
busy  out  1  state != IDLE

Behaviour:
- Single clock, reset synchronous active-high. All registered outputs and state clear on reset: state = IDLE, ulpi_stp = 0, rd_data = 0, rd_valid/done/aborted = 0, dir_r = 0.
- dir_r is the registered ulpi_dir. turnaround = ulpi_dir != dir_r.
- ulpi_data_oe = !ulpi_dir && !turnaround (combinational).
- ulpi_data_out is combinational from state:
  - IDLE: 8'h00 (NOOP).
  - CMD: transmit 8'h40|PID, reg write 8'h80|addr, reg read 8'hC0|addr.
  - WDATA: latched wdata.
  - TXDATA: tx_data.
  - STP: 8'h00, or 8'hFF after an underrun.
- req_ready = (state == IDLE) && req_valid && req_type != 3 && !ulpi_dir && !turnaround. On acceptance, latch type/addr/wdata/pid; next state CMD.
- CMD: hold the command until ulpi_nxt = 1 with oe = 1.
  - Write -> WDATA; read -> RD_TURN; transmit -> TXDATA.
  - If ulpi_dir rises first -> ABORT.
- WDATA: on nxt -> STP. Dir rise -> ABORT.
- TXDATA: tx_ready = ulpi_nxt && oe && tx_valid; a byte is consumed when tx_ready = 1.
  - Byte consumed with tx_last -> STP (data 00).
  - nxt = 1 && tx_valid = 0 (underrun) -> STP with data FF; the request ends as aborted.
  - Dir rise -> ABORT; no stp is driven.
- STP: ulpi_stp = 1 for exactly one cycle, then IDLE.
  - done pulses in that cycle, or aborted on underrun.
  - If dir rises during STP, stp is still driven; done/aborted is reported as decided.
- RD_TURN: wait for dir = 1.
  - dir = 1 && nxt = 1 (PHY receive pre-empts) -> ABORT.
  - dir = 1 && nxt = 0 -> RD_DATA.
- RD_DATA: next cycle with dir = 1, capture ulpi_data_in into rd_data; rd_valid and done pulse; -> RD_END.
  - dir = 0 in RD_DATA -> ABORT.
- RD_END: wait for dir = 0, then IDLE. The idle-side turnaround cycle is covered by oe gating.
- ABORT: aborted pulses for one cycle; wait for dir = 0, then IDLE. tx_ready = 0 throughout.
- reset mid-operation: immediate IDLE, stp = 0, no done/aborted pulse.
- At most one of done/aborted pulses per request; rd_valid only accompanies done.

Optional Feature:
ULPI_TX_REG_RETRY_EN:
- Defined: register ops aborted by dir are not reported. After dir = 0 the block re-enters CMD with the latched request, up to MAX_RETRY times. On exhausting retries, aborted pulses. Transmit aborts are always reported.
- Undefined: every abort pulses aborted once and returns to IDLE; MAX_RETRY is unused.

Test Plan:
- Reg write addr 0x0A, data 0x55; PHY nxt one cycle after CMD and again in WDATA -> bus shows 0x8A, then 0x55, then stp = 1 for one cycle with data 0x00; done pulses once.
- Reg read addr 0x16; PHY nxt, dir = 1 one cycle, then drives 0x3C -> bus shows 0xD6, oe drops with dir, rd_data = 0x3C with rd_valid and done in the same cycle.
- Transmit PID 0x3 with bytes 0x11, 0x22, 0x33 (last) and nxt on each -> bus shows 0x43, 0x11, 0x22, 0x33, then stp with 0x00; tx_ready pulses 3 times; done.
- Transmit with tx_valid low when nxt = 1 after the first byte -> stp with data 0xFF; aborted pulses; done never pulses.
- dir rises while CMD 0x8A is held, nxt never high -> oe = 0 that cycle, aborted pulses (macro off); with macro on and MAX_RETRY = 3, 0x8A is re-issued after dir falls.
- Reset asserted during TXDATA -> next cycle state IDLE, stp = 0, busy = 0, no done/aborted.
